// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file: mode encodings, default
// register indices and sizing helpers.
package regfile_pkg;

    typedef enum logic [1:0] {
        MODE_KERNEL = 2'd0,
        MODE_SUPER  = 2'd1,
        MODE_USER   = 2'd3
    } mode_e;

    localparam int SP_IDX_DEFAULT = 6;
    localparam int PC_IDX_DEFAULT = 7;

    // One logical SP slot is replaced by SP_BANKS physical copies.
    function automatic int phys_count(input int nregs, input int sp_banks);
        return nregs - 1 + sp_banks;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_banked_if.sv
// Register-select, write and read-data bundle between the microsequencer
// and the banked register file.
interface regfile_banked_if #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int SP_BANKS = 2
);
    import regfile_pkg::*;

    localparam int SW = $clog2(NREGS);
    localparam int MW = clog2_min1(SP_BANKS);

    logic [SW-1:0]    sela;
    logic [SW-1:0]    selb;
    logic [MW-1:0]    mode;
    logic [MW-1:0]    prev_mode;
    logic             prev_en;
    logic             we;
    logic [WIDTH-1:0] w;
    logic             inc_en;
    logic [SW-1:0]    inc_sel;
    logic [3:0]       inc_delta;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;

    modport master (
        output sela, selb, mode, prev_mode, prev_en, we, w, inc_en, inc_sel, inc_delta,
        input  a, b, pc
    );

    modport slave (
        input  sela, selb, mode, prev_mode, prev_en, we, w, inc_en, inc_sel, inc_delta,
        output a, b, pc
    );

endinterface

// File: rtl/regfile_addr_map.sv
// Maps a logical register select plus mode onto a physical storage index;
// ok is low for selects beyond the logical register count.
module regfile_addr_map
    import regfile_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int SP_IDX   = SP_IDX_DEFAULT,
    parameter int SP_BANKS = 2
) (
    input  logic [$clog2(NREGS)-1:0]                        sel,
    input  logic [clog2_min1(SP_BANKS)-1:0]                 mode,
    output logic [$clog2(phys_count(NREGS, SP_BANKS))-1:0]  phys,
    output logic                                            ok
);

    localparam int PW = $clog2(phys_count(NREGS, SP_BANKS));

    int bank;

    // Bank 0 lives at SP_IDX itself; higher banks sit past the last logical register.
    always_comb begin
        bank = (int'(mode) >= SP_BANKS) ? SP_BANKS - 1 : int'(mode);
        ok   = int'(sel) < NREGS;
        phys = '0;
        if (ok) begin
            if (int'(sel) == SP_IDX && bank != 0) begin
                phys = PW'(NREGS - 1 + bank);
            end else begin
                phys = PW'(sel);
            end
        end
    end

endmodule

// File: rtl/regfile_banked.sv
// Datapath register file with per-mode stack-pointer banks, a main write port,
// an increment port, previous-mode access and optional write-to-read bypass.
module regfile_banked
    import regfile_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               NREGS    = 8,
    parameter int               SP_IDX   = SP_IDX_DEFAULT,
    parameter int               SP_BANKS = 2,
    parameter int               BYPASS   = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             reset,
    regfile_banked_if.slave bus
);

    localparam int MW     = clog2_min1(SP_BANKS);
    localparam int NPHYS  = phys_count(NREGS, SP_BANKS);
    localparam int PW     = $clog2(NPHYS);
    localparam int PC_IDX = NREGS - 1;

    logic [WIDTH-1:0] regs [NPHYS];
    logic [MW-1:0]    eff_mode;
    logic [PW-1:0]    a_phys, b_phys, w_phys, i_phys;
    logic             a_ok, b_ok, w_ok, i_ok;
    logic             w_fire, i_fire;
    logic [WIDTH-1:0] inc_val;

    assign eff_mode = bus.prev_en ? bus.prev_mode : bus.mode;

    regfile_addr_map #(.NREGS(NREGS), .SP_IDX(SP_IDX), .SP_BANKS(SP_BANKS)) u_map_a (
        .sel(bus.sela), .mode(bus.mode), .phys(a_phys), .ok(a_ok)
    );
    regfile_addr_map #(.NREGS(NREGS), .SP_IDX(SP_IDX), .SP_BANKS(SP_BANKS)) u_map_b (
        .sel(bus.selb), .mode(eff_mode), .phys(b_phys), .ok(b_ok)
    );
    regfile_addr_map #(.NREGS(NREGS), .SP_IDX(SP_IDX), .SP_BANKS(SP_BANKS)) u_map_w (
        .sel(bus.selb), .mode(eff_mode), .phys(w_phys), .ok(w_ok)
    );
    regfile_addr_map #(.NREGS(NREGS), .SP_IDX(SP_IDX), .SP_BANKS(SP_BANKS)) u_map_i (
        .sel(bus.inc_sel), .mode(eff_mode), .phys(i_phys), .ok(i_ok)
    );

    // The main write wins a physical-index collision, so the increment is dropped.
    assign w_fire  = bus.we && w_ok;
    assign i_fire  = bus.inc_en && i_ok && !(w_fire && (w_phys == i_phys));
    assign inc_val = regs[i_phys] + {{(WIDTH-4){bus.inc_delta[3]}}, bus.inc_delta};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NPHYS; i++) begin
                regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
            end
        end else begin
            if (i_fire) regs[i_phys] <= inc_val;
            if (w_fire) regs[w_phys] <= bus.w;
        end
    end

    always_comb begin
        bus.a = a_ok ? regs[a_phys] : '0;
        bus.b = b_ok ? regs[b_phys] : '0;
        if (BYPASS != 0 && !reset) begin
            if (a_ok && w_fire && w_phys == a_phys)      bus.a = bus.w;
            else if (a_ok && i_fire && i_phys == a_phys) bus.a = inc_val;
            if (b_ok && w_fire && w_phys == b_phys)      bus.b = bus.w;
            else if (b_ok && i_fire && i_phys == b_phys) bus.b = inc_val;
        end
    end

    assign bus.pc = regs[PC_IDX];

endmodule

// File: tb/tb_regfile_banked.sv
// Scoreboard bench for regfile_banked: 16-bit builds with and without bypass,
// plus a 32-bit 16-register 4-bank build, against a logical-register model.
module tb_regfile_banked;
    import regfile_pkg::*;

    localparam logic [15:0] RPC16 = 16'o173000;
    localparam logic [31:0] RPC32 = 32'h0000_0400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  st_sela = '0, st_selb = '0, st_inc_sel = '0, st_delta = '0;
    logic [1:0]  st_mode = '0, st_pmode = '0;
    logic        st_pen = 1'b0, st_we = 1'b0, st_inc_en = 1'b0;
    logic [31:0] st_w = '0;

    regfile_banked_if #(.WIDTH(16), .NREGS(8),  .SP_BANKS(2)) bus_byp  ();
    regfile_banked_if #(.WIDTH(16), .NREGS(8),  .SP_BANKS(2)) bus_nob  ();
    regfile_banked_if #(.WIDTH(32), .NREGS(16), .SP_BANKS(4)) bus_wide ();

    assign bus_byp.sela      = st_sela[2:0];    assign bus_nob.sela      = st_sela[2:0];    assign bus_wide.sela      = st_sela;
    assign bus_byp.selb      = st_selb[2:0];    assign bus_nob.selb      = st_selb[2:0];    assign bus_wide.selb      = st_selb;
    assign bus_byp.inc_sel   = st_inc_sel[2:0]; assign bus_nob.inc_sel   = st_inc_sel[2:0]; assign bus_wide.inc_sel   = st_inc_sel;
    assign bus_byp.mode      = st_mode[0];      assign bus_nob.mode      = st_mode[0];      assign bus_wide.mode      = st_mode;
    assign bus_byp.prev_mode = st_pmode[0];     assign bus_nob.prev_mode = st_pmode[0];     assign bus_wide.prev_mode = st_pmode;
    assign bus_byp.prev_en   = st_pen;          assign bus_nob.prev_en   = st_pen;          assign bus_wide.prev_en   = st_pen;
    assign bus_byp.we        = st_we;           assign bus_nob.we        = st_we;           assign bus_wide.we        = st_we;
    assign bus_byp.w         = st_w[15:0];      assign bus_nob.w         = st_w[15:0];      assign bus_wide.w         = st_w;
    assign bus_byp.inc_en    = st_inc_en;       assign bus_nob.inc_en    = st_inc_en;       assign bus_wide.inc_en    = st_inc_en;
    assign bus_byp.inc_delta = st_delta;        assign bus_nob.inc_delta = st_delta;        assign bus_wide.inc_delta = st_delta;

    regfile_banked #(.WIDTH(16), .NREGS(8), .SP_IDX(6), .SP_BANKS(2), .BYPASS(1), .RESET_PC(RPC16))
        dut_byp (.clk(clk), .reset(reset), .bus(bus_byp));
    regfile_banked #(.WIDTH(16), .NREGS(8), .SP_IDX(6), .SP_BANKS(2), .BYPASS(0), .RESET_PC(RPC16))
        dut_nob (.clk(clk), .reset(reset), .bus(bus_nob));
    regfile_banked #(.WIDTH(32), .NREGS(16), .SP_IDX(6), .SP_BANKS(4), .BYPASS(1), .RESET_PC(RPC32))
        dut_wide (.clk(clk), .reset(reset), .bus(bus_wide));

    // Logical model: ordinary registers plus one stack pointer per mode.
    int unsigned cfg_nregs = 8, cfg_banks = 2;
    logic [31:0] cfg_mask = 32'h0000_FFFF, cfg_rpc = {16'h0, RPC16};
    int          phase = 0;
    bit          chk_en = 1'b1;
    logic [31:0] m_reg [16];
    logic [31:0] m_sp  [4];

    typedef struct {
        string       name;
        int          ph;
        bit          chk;
        logic [31:0] a_byp, b_byp, a_nob, b_nob, pc;
    } exp_t;
    exp_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int unsigned bank_of(input logic [1:0] md);
        return (int'(md) >= int'(cfg_banks)) ? cfg_banks - 1 : int'(md);
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] sel, input logic [1:0] md);
        if (sel >= cfg_nregs) return '0;
        if (sel == 4'd6) return m_sp[bank_of(md)];
        return m_reg[sel];
    endfunction

    function automatic void mwrite(input logic [3:0] sel, input logic [1:0] md, input logic [31:0] v);
        if (sel >= cfg_nregs) return;
        if (sel == 4'd6) m_sp[bank_of(md)] = v & cfg_mask;
        else m_reg[sel] = v & cfg_mask;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        for (int i = 0; i < 4; i++) m_sp[i] = '0;
        m_reg[cfg_nregs - 1] = cfg_rpc;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // One clock of stimulus; the expectation is queued and the model advanced.
    task automatic step(input string name, input logic rst,
                        input logic [3:0] sa, input logic [3:0] sbs,
                        input logic [1:0] md, input logic [1:0] pm, input logic pen,
                        input logic we, input logic [31:0] wd,
                        input logic ie, input logic [3:0] isel, input logic [3:0] dl);
        exp_t        e;
        logic [1:0]  em;
        logic [31:0] iv;
        @(posedge clk);
        #1;
        reset = rst; st_sela = sa; st_selb = sbs; st_mode = md; st_pmode = pm; st_pen = pen;
        st_we = we; st_w = wd; st_inc_en = ie; st_inc_sel = isel; st_delta = dl;
        em     = pen ? pm : md;
        e.name = name;
        e.ph   = phase;
        e.chk  = chk_en;
        e.a_nob = mread(sa, md);
        e.b_nob = mread(sbs, em);
        e.pc    = m_reg[cfg_nregs - 1];
        if (rst) begin
            model_reset();
        end else begin
            if (ie) begin
                iv = mread(isel, em) + {{28{dl[3]}}, dl};
                mwrite(isel, em, iv);
            end
            if (we) mwrite(sbs, em, wd);
        end
        e.a_byp = rst ? e.a_nob : mread(sa, md);
        e.b_byp = rst ? e.b_nob : mread(sbs, em);
        exp_q.push_back(e);
    endtask

    task automatic rd(input string name, input logic [3:0] sa, input logic [3:0] sbs,
                      input logic [1:0] md);
        step(name, 1'b0, sa, sbs, md, 2'd0, 1'b0, 1'b0, '0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic wr(input string name, input logic [3:0] sbs, input logic [1:0] md,
                      input logic [31:0] wd);
        step(name, 1'b0, sbs, sbs, md, 2'd0, 1'b0, 1'b1, wd, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic rand_cycles(input int n);
        logic [3:0]  sa, sbs, isel, dl;
        logic [1:0]  md, pm;
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            sa   = 4'($urandom_range(0, cfg_nregs - 1));
            sbs  = 4'($urandom_range(0, cfg_nregs - 1));
            isel = ($urandom_range(0, 3) == 0) ? sbs : 4'($urandom_range(0, cfg_nregs - 1));
            md   = 2'($urandom_range(0, cfg_banks - 1));
            pm   = 2'($urandom_range(0, cfg_banks - 1));
            case ($urandom_range(0, 3))
                0:       wd = '0;
                1:       wd = cfg_mask;
                default: wd = $urandom() & cfg_mask;
            endcase
            case ($urandom_range(0, 4))
                0: dl = 4'd1;
                1: dl = 4'd2;
                2: dl = 4'hF;
                3: dl = 4'hE;
                default: dl = 4'($urandom());
            endcase
            step("rand", ($urandom_range(0, 39) == 0), sa, sbs, md, pm, 1'($urandom()),
                 1'($urandom()), wd, 1'($urandom()), isel, dl);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.chk) continue;
                if (e.ph == 0) begin
                    check({e.name, "/byp.a"}, {16'h0, bus_byp.a},  e.a_byp);
                    check({e.name, "/byp.b"}, {16'h0, bus_byp.b},  e.b_byp);
                    check({e.name, "/byp.pc"}, {16'h0, bus_byp.pc}, e.pc);
                    check({e.name, "/nob.a"}, {16'h0, bus_nob.a},  e.a_nob);
                    check({e.name, "/nob.b"}, {16'h0, bus_nob.b},  e.b_nob);
                    check({e.name, "/nob.pc"}, {16'h0, bus_nob.pc}, e.pc);
                end else begin
                    check({e.name, "/wide.a"},  bus_wide.a,  e.a_byp);
                    check({e.name, "/wide.b"},  bus_wide.b,  e.b_byp);
                    check({e.name, "/wide.pc"}, bus_wide.pc, e.pc);
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        // Reset with a competing write: R0 must stay zero.
        step("rst_we", 1'b1, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b1, 32'h1234, 1'b0, 4'd0, 4'd0);
        rd("post_rst_r0_pc", 4'd0, 4'd7, 2'd0);
        for (int i = 1; i < 8; i++) rd("post_rst_rd", 4'(i), 4'(7 - i), 2'd0);
        rd("post_rst_usp", 4'd6, 4'd6, 2'd1);

        // Stack-pointer banking and previous-mode access.
        wr("ksp_wr", 4'd6, 2'd0, 32'h1000);
        wr("usp_wr", 4'd6, 2'd1, 32'h2000);
        rd("ksp_rd", 4'd6, 4'd6, 2'd0);
        rd("usp_rd", 4'd6, 4'd6, 2'd1);
        step("prev_rd", 1'b0, 4'd6, 4'd6, 2'd0, 2'd1, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);

        // Increment wrap-around and PC stepping.
        wr("r2_wr", 4'd2, 2'd0, 32'hFFFF);
        step("r2_inc", 1'b0, 4'd2, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 4'd2, 4'd1);
        wr("r3_wr", 4'd3, 2'd0, 32'h0000);
        step("r3_dec", 1'b0, 4'd3, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 4'd3, 4'hE);
        wr("pc_wr", 4'd7, 2'd0, 32'h0100);
        step("pc_inc", 1'b0, 4'd7, 4'd7, 2'd0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 4'd7, 4'd2);
        rd("pc_after", 4'd2, 4'd3, 2'd0);

        // Simultaneous W and INC, same and different targets.
        wr("r4_wr", 4'd4, 2'd0, 32'h0010);
        wr("r5_wr", 4'd5, 2'd0, 32'h0050);
        step("w_inc_same", 1'b0, 4'd4, 4'd4, 2'd0, 2'd0, 1'b0, 1'b1, 32'hAAAA, 1'b1, 4'd4, 4'd2);
        rd("w_inc_same_rd", 4'd4, 4'd5, 2'd0);
        step("w_inc_diff", 1'b0, 4'd5, 4'd4, 2'd0, 2'd0, 1'b0, 1'b1, 32'hAAAA, 1'b1, 4'd5, 4'd2);
        rd("w_inc_diff_rd", 4'd4, 4'd5, 2'd0);

        // Bypass visibility, and no bypass across SP banks.
        step("byp_r1", 1'b0, 4'd1, 4'd1, 2'd0, 2'd0, 1'b0, 1'b1, 32'h5555, 1'b0, 4'd0, 4'd0);
        rd("byp_r1_rd", 4'd1, 4'd0, 2'd0);
        step("ksp_wr_usp_rd", 1'b0, 4'd6, 4'd6, 2'd1, 2'd0, 1'b1, 1'b1, 32'h7777, 1'b0, 4'd0, 4'd0);
        rd("usp_rd2", 4'd6, 4'd6, 2'd0);

        // Reset in the middle of activity.
        step("mid_rst", 1'b1, 4'd1, 4'd6, 2'd1, 2'd0, 1'b0, 1'b1, 32'h9999, 1'b1, 4'd7, 4'd2);
        rd("mid_rst_rd", 4'd1, 4'd7, 2'd1);
        rand_cycles(300);

        // Wide build: 32-bit, 16 registers, four SP banks.
        phase = 1; cfg_nregs = 16; cfg_banks = 4; cfg_mask = 32'hFFFF_FFFF; cfg_rpc = RPC32;
        chk_en = 1'b0;
        step("wide_rst", 1'b1, 4'd0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        chk_en = 1'b1;
        rd("wide_rst_rd", 4'd6, 4'd15, 2'd3);
        for (int m = 0; m < 4; m++) wr("wide_sp_wr", 4'd6, 2'(m), 32'h1111_0000 * (m + 1));
        wr("wide_r15_wr", 4'd15, 2'd0, 32'hCAFE_0000);
        for (int m = 0; m < 4; m++) rd("wide_sp_rd", 4'd6, 4'd15, 2'(m));
        step("wide_prev", 1'b0, 4'd6, 4'd6, 2'd3, 2'd2, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        wr("wide_r9_wr", 4'd9, 2'd0, 32'hFFFF_FFFF);
        step("wide_wrap", 1'b0, 4'd9, 4'd9, 2'd0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 4'd9, 4'd1);
        rd("wide_wrap_rd", 4'd9, 4'd15, 2'd0);
        rand_cycles(300);

        rd("drain", 4'd0, 4'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
Parametrised successor to the single-set datapath register file. Two combinational read ports and one main write port, as before. Adds:
- Per-mode stack-pointer banking (kernel/supervisor/user R6).
- A second write port for autoincrement/autodecrement.
- Previous-mode access for MFPI/MTPI.
- Optional same-cycle write-to-read bypass.
- A dedicated PC output.
Sits in the datapath between the microsequencer's register selects and the ALU A/B buses.

Parameters:
- WIDTH, 16: register width in bits.
- NREGS, 8: logical registers R0..R(NREGS-1); PC is R(NREGS-1).
- SP_IDX, 6: logical index of the banked stack pointer.
- SP_BANKS, 2: number of SP copies, one per mode (2 = kernel/user, 4 = 11/70 style).
- BYPASS, 1: 1 = a write is visible on A/B in the same cycle; 0 = visible next cycle.
- RESET_PC, 0: value loaded into PC on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- sela  in  SW=clog2(NREGS)  bus A register select.
- selb  in  SW  bus B register select; also the W write target.
- mode  in  MW=max(1,clog2(SP_BANKS))  current mode; selects the SP bank.
- prev_mode  in  MW  previous mode.
- prev_en  in  1  bus B, W and INC accesses to R6 use prev_mode.
- we  in  1  write w to R[selb].
- w  in  WIDTH  write data.
- inc_en  in  1  apply inc_delta to R[inc_sel].
- inc_sel  in  SW  increment target.
- inc_delta  in  4  signed delta (±1, ±2 in practice).
- a  out  WIDTH  R[sela].
- b  out  WIDTH  R[selb].
- pc  out  WIDTH  always R(NREGS-1), registered value (never bypassed).

Behaviour:
- Physical storage:
  - NREGS-1+SP_BANKS words.
  - Logical index SP_IDX maps to bank (effective mode); every other index maps one-to-one.
- Effective mode:
  - Bus A always uses `mode`.
  - Bus B, W and INC use prev_mode when prev_en=1, otherwise `mode`.
- Reads:
  - Combinational from the mapped physical word.
  - Mode/prev_en changes take effect in the same cycle.
  - Select values ≥ NREGS (only possible with non-power-of-2 NREGS) read 0.
- W write:
  - On posedge with we=1, physical(selb, effective mode) <= w.
- INC write:
  - On posedge with inc_en=1, physical(inc_sel, effective mode) <= old value + sign-extended inc_delta.
  - Modulo 2^WIDTH: 0xFFFF + 1 = 0x0000; 0x0000 - 2 = 0xFFFE.
- Simultaneous W and INC:
  - Different physical targets: both apply.
  - Same physical target: W wins and the increment is discarded.
- Bypass (BYPASS=1):
  - If a read port's physical index equals a pending write's physical index, that port shows the value that will be stored.
  - W priority applies; an INC-only hit shows the old value plus delta.
  - Matching compares physical indices, so a write to the kernel SP does not bypass a user-SP read.
  - Never bypass during reset.
- Reset:
  - Every physical word, including all SP banks, goes to 0; PC goes to RESET_PC.
  - Reset overrides we/inc_en in the same cycle, including reset asserted mid-sequence.
  - Outputs in the cycle after reset:
    - a and b equal the selected reset values (0, or RESET_PC for PC).
    - pc equals RESET_PC.
- Latency:
  - 0 cycles from select to read.
  - Writes become visible on the next cycle (same cycle with BYPASS=1).
- No internal FSM beyond the storage; there are no illegal states.

Decomposition:
- Shared package regfile_pkg:
  - Mode constants MODE_KERNEL=0, MODE_SUPER=1, MODE_USER=3; a 2-bank build maps user to bank 1.
  - SP_IDX and PC index defaults.
  - Physical-count helper function.
- One natural sub-module: regfile_addr_map.
  - Combinational (sel, mode) -> physical index.
  - Instantiated four times: A, B, W, INC.
- Storage, write arbitration and bypass stay in regfile_banked.

Test Plan:
1. Reset with RESET_PC=0o173000 -> pc=0x F600, R0..R5 and both SP banks read 0; reset asserted together with we=1, selb=0, w=0x1234 -> R0 stays 0.
2. mode=0, write R6=0x1000; mode=1, write R6=0x2000 -> reads give 0x1000 (mode=0) and 0x2000 (mode=1); with mode=0, prev_en=1, prev_mode=1, b on selb=6 gives 0x2000 while a on sela=6 gives 0x1000.
3. R2=0xFFFF, inc_en=1, inc_sel=2, delta=+1 -> R2=0x0000; R3=0x0000, delta=-2 -> 0xFFFE; PC=0x0100, delta=+2 -> pc=0x0102 next cycle.
4. we=1, selb=4, w=0xAAAA together with inc_en=1, inc_sel=4, delta=+2 on R4=0x0010 -> R4=0xAAAA; with inc_sel=5 instead -> R4=0xAAAA and R5=old+2.
5. BYPASS=1: we=1, selb=1, w=0x5555, sela=1 -> a=0x5555 in the same cycle; BYPASS=0 -> a shows the old value until the next cycle; kernel-SP write with a user-SP read -> no bypass.
6. NREGS=16, WIDTH=32, SP_BANKS=4 build: write all 4 SP banks distinctly plus R15, read them back, and check +1 wrap at 0xFFFFFFFF.
